// File: rtl/instr_encoder_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder/loader.
// Op numbering follows the core decoder's order; in_op values above OP_BLT are illegal.
package instr_encoder_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLTU, OP_SRL,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW, OP_JALR,
        OP_SW, OP_SB, OP_BEQ, OP_JAL, OP_ECALL,
        OP_SLLI, OP_SRLI, OP_SRAI, OP_BNE, OP_BLT
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_J, FMT_SYS
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_RUN, ST_FULL
    } state_e;

    // Upper five opcode bits; the low two bits are always 2'b11.
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True when v is representable as a bits-wide two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_fmt_pack.sv
// Combinational RV32I word assembly: op + fields -> {word, illegal}.
// Fields a format does not use are left zero in the word.
module instr_fmt_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    fmt_e       fmt;
    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad_op;
    logic       bad_imm;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fmt    = FMT_SYS;
        opc    = OPC_SYSTEM;
        f3     = 3'b000;
        f7     = F7_BASE;
        bad_op = 1'b0;
        case (op_e'(op))
            OP_ADD:   begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_ADD;  end
            OP_SUB:   begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
            OP_AND:   begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_AND;  end
            OP_OR:    begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_OR;   end
            OP_SLT:   begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_SLT;  end
            OP_SLTU:  begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_SLTU; end
            OP_SRL:   begin fmt = FMT_R;     opc = OPC_OP;     f3 = F3_SR;   end
            OP_ADDI:  begin fmt = FMT_I;     opc = OPC_OP_IMM; f3 = F3_ADD;  end
            OP_ANDI:  begin fmt = FMT_I;     opc = OPC_OP_IMM; f3 = F3_AND;  end
            OP_ORI:   begin fmt = FMT_I;     opc = OPC_OP_IMM; f3 = F3_OR;   end
            OP_XORI:  begin fmt = FMT_I;     opc = OPC_OP_IMM; f3 = F3_XOR;  end
            OP_SLTI:  begin fmt = FMT_I;     opc = OPC_OP_IMM; f3 = F3_SLT;  end
            OP_SLTIU: begin fmt = FMT_I;     opc = OPC_OP_IMM; f3 = F3_SLTU; end
            OP_LW:    begin fmt = FMT_I;     opc = OPC_LOAD;   f3 = F3_W;    end
            OP_JALR:  begin fmt = FMT_I;     opc = OPC_JALR;   f3 = F3_ADD;  end
            OP_SW:    begin fmt = FMT_S;     opc = OPC_STORE;  f3 = F3_W;    end
            OP_SB:    begin fmt = FMT_S;     opc = OPC_STORE;  f3 = F3_B;    end
            OP_BEQ:   begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = F3_BEQ;  end
            OP_BNE:   begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = F3_BNE;  end
            OP_BLT:   begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = F3_BLT;  end
            OP_JAL:   begin fmt = FMT_J;     opc = OPC_JAL;    end
            OP_ECALL: begin fmt = FMT_SYS;   opc = OPC_SYSTEM; end
            OP_SLLI:  begin fmt = FMT_SHIFT; opc = OPC_OP_IMM; f3 = F3_SLL;  end
            OP_SRLI:  begin fmt = FMT_SHIFT; opc = OPC_OP_IMM; f3 = F3_SR;   end
            OP_SRAI:  begin fmt = FMT_SHIFT; opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; end
            default:  bad_op = 1'b1;
        endcase
    end

    always_comb begin
        word    = '0;
        bad_imm = 1'b0;
        case (fmt)
            FMT_R:     word = {f7, rs2, rs1, f3, rd, opc, 2'b11};
            FMT_I: begin
                word    = {imm[11:0], rs1, f3, rd, opc, 2'b11};
                bad_imm = !fits_signed(imm, 12);
            end
            FMT_SHIFT: begin
                word    = {f7, imm[4:0], rs1, f3, rd, opc, 2'b11};
                bad_imm = |imm[31:5];
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opc, 2'b11};
                bad_imm = !fits_signed(imm, 12);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc, 2'b11};
                bad_imm = imm[0] || !fits_signed(imm, 13);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc, 2'b11};
                bad_imm = imm[0] || !fits_signed(imm, 21);
            end
            default:   word = {25'd0, OPC_SYSTEM, 2'b11};
        endcase
    end

    assign illegal = bad_op || bad_imm;

endmodule

// File: rtl/instr_encoder.sv
// Session FSM, address/count tracking, error capture and registered memory write port
// wrapped around the combinational instruction packer.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [4:0]        err_op
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word;
    logic              illegal;
    logic              xfer, accept, reject, last_write;

    instr_fmt_pack u_pack (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (word),
        .illegal (illegal)
    );

    assign in_ready   = (state_q == ST_RUN) && !start && !finish;
    assign xfer       = in_valid && in_ready;
    assign accept     = xfer && !illegal;
    assign reject     = xfer && illegal;
    assign last_write = accept && (count == CAP - 1'b1);
    assign full       = (count == CAP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start)           state_d = ST_RUN;
                else if (finish)     state_d = ST_IDLE;
                else if (last_write) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (start)       state_d = ST_RUN;
                else if (finish) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_q    <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_op    <= '0;
        end else begin
            mem_we <= accept;
            if (start) begin
                addr_q <= '0;
                count  <= '0;
                err    <= 1'b0;
            end else if (accept) begin
                mem_addr  <= addr_q;
                mem_wdata <= word;
                addr_q    <= addr_q + 1'b1;
                count     <= count + 1'b1;
            end else if (reject) begin
                // Only the first rejection of a session is recorded.
                err <= 1'b1;
                if (!err) err_op <= in_op;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural session/encoding model.
module tb_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full, err;
    logic [4:0]    err_op;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full),
        .err(err), .err_op(err_op)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: session mode 0 idle, 1 running, 2 full.
    int          m_mode, m_addr, m_count, m_err_op;
    bit          m_err, m_we;
    logic [31:0] m_maddr, m_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_count = 0; m_err = 0; m_err_op = 0;
        m_we = 0; m_maddr = 0; m_wdata = 0;
    endtask

    // Reference encoder built from the ISA field layout with plain integer arithmetic.
    function automatic void ref_encode(input int op, input logic [31:0] rd, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm,
                                       output logic [31:0] w, output bit ok);
        int kind, opc, f3, f7, v;
        logic [31:0] u;
        kind = 0; opc = 0; f3 = 0; f7 = 0; u = imm; v = int'(imm);
        w = 0; ok = 1;
        case (op)
            0:  begin kind = 0; opc = 'h33; f3 = 0; end
            1:  begin kind = 0; opc = 'h33; f3 = 0; f7 = 'h20; end
            2:  begin kind = 0; opc = 'h33; f3 = 7; end
            3:  begin kind = 0; opc = 'h33; f3 = 6; end
            4:  begin kind = 0; opc = 'h33; f3 = 2; end
            5:  begin kind = 0; opc = 'h33; f3 = 3; end
            6:  begin kind = 0; opc = 'h33; f3 = 5; end
            7:  begin kind = 1; opc = 'h13; f3 = 0; end
            8:  begin kind = 1; opc = 'h13; f3 = 7; end
            9:  begin kind = 1; opc = 'h13; f3 = 6; end
            10: begin kind = 1; opc = 'h13; f3 = 4; end
            11: begin kind = 1; opc = 'h13; f3 = 2; end
            12: begin kind = 1; opc = 'h13; f3 = 3; end
            13: begin kind = 1; opc = 'h03; f3 = 2; end
            14: begin kind = 1; opc = 'h67; f3 = 0; end
            15: begin kind = 3; opc = 'h23; f3 = 2; end
            16: begin kind = 3; opc = 'h23; f3 = 0; end
            17: begin kind = 4; opc = 'h63; f3 = 0; end
            18: begin kind = 5; opc = 'h6F; end
            19: begin kind = 6; end
            20: begin kind = 2; opc = 'h13; f3 = 1; end
            21: begin kind = 2; opc = 'h13; f3 = 5; end
            22: begin kind = 2; opc = 'h13; f3 = 5; f7 = 'h20; end
            23: begin kind = 4; opc = 'h63; f3 = 1; end
            24: begin kind = 4; opc = 'h63; f3 = 4; end
            default: begin kind = 7; ok = 0; end
        endcase
        case (kind)
            0: w = 32'(f7) << 25 | rs2 << 20 | rs1 << 15 | 32'(f3) << 12 | rd << 7 | 32'(opc);
            1: begin
                ok = (v >= -2048) && (v <= 2047);
                w = (u & 32'hFFF) << 20 | rs1 << 15 | 32'(f3) << 12 | rd << 7 | 32'(opc);
            end
            2: begin
                ok = (v >= 0) && (v <= 31);
                w = 32'(f7) << 25 | (u & 31) << 20 | rs1 << 15 | 32'(f3) << 12 | rd << 7 | 32'(opc);
            end
            3: begin
                ok = (v >= -2048) && (v <= 2047);
                w = ((u >> 5) & 127) << 25 | rs2 << 20 | rs1 << 15 | 32'(f3) << 12
                    | (u & 31) << 7 | 32'(opc);
            end
            4: begin
                ok = (v % 2 == 0) && (v >= -4096) && (v <= 4094);
                w = ((u >> 12) & 1) << 31 | ((u >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15
                    | 32'(f3) << 12 | ((u >> 1) & 15) << 8 | ((u >> 11) & 1) << 7 | 32'(opc);
            end
            5: begin
                ok = (v % 2 == 0) && (v >= -1048576) && (v <= 1048574);
                w = ((u >> 20) & 1) << 31 | ((u >> 1) & 1023) << 21 | ((u >> 11) & 1) << 20
                    | ((u >> 12) & 255) << 12 | rd << 7 | 32'(opc);
            end
            6: w = 32'h0000_0073;
            default: w = 0;
        endcase
    endfunction

    task automatic chk_outputs(input string tag);
        check({tag, ".mem_we"}, 32'(mem_we), 32'(m_we));
        check({tag, ".mem_addr"}, 32'(mem_addr), m_maddr);
        check({tag, ".mem_wdata"}, mem_wdata, m_wdata);
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".full"}, 32'(full), 32'(m_count == CAP));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".err_op"}, 32'(err_op), 32'(m_err_op));
    endtask

    // One clock: check in_ready for the driven inputs, advance the model, compare after the edge.
    task automatic tick(input string tag);
        logic [31:0] w;
        bit ok;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_mode == 1 && !start && !finish));
        m_we = 0;
        if (start) begin
            m_mode = 1; m_addr = 0; m_count = 0; m_err = 0;
        end else if (finish) begin
            m_mode = 0;
        end else if (m_mode == 1 && in_valid) begin
            ref_encode(int'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm, w, ok);
            if (ok) begin
                m_we = 1; m_maddr = 32'(m_addr); m_wdata = w;
                m_addr = (m_addr + 1) % CAP;
                m_count++;
                if (m_count == CAP) m_mode = 2;
            end else begin
                if (!m_err) m_err_op = int'(in_op);
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        chk_outputs(tag);
    endtask

    task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_valid = 1'b1;
        in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0; start = 1'b1;
        tick("start");
        start = 1'b0;
    endtask

    typedef struct {
        int          op, rd, rs1, rs2, imm;
        bit          we;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{0,  3, 1, 2, 0,        1, 32'h002081B3};
        vecs[1]  = '{7,  1, 0, 0, -1,       1, 32'hFFF00093};
        vecs[2]  = '{15, 31, 1, 2, 8,       1, 32'h0020A423};
        vecs[3]  = '{17, 5, 1, 2, -4,       1, 32'hFE208EE3};
        vecs[4]  = '{18, 1, 7, 9, 8,        1, 32'h008000EF};
        vecs[5]  = '{19, 4, 5, 6, 123,      1, 32'h00000073};
        vecs[6]  = '{22, 1, 2, 0, 31,       1, 32'h41F15093};
        vecs[7]  = '{1,  1, 2, 3, 0,        1, 32'h403100B3};
        vecs[8]  = '{17, 0, 1, 2, 3,        0, 32'h0};
        vecs[9]  = '{7,  1, 0, 0, 4096,     0, 32'h0};
        vecs[10] = '{20, 1, 2, 0, 32,       0, 32'h0};
        vecs[11] = '{25, 1, 2, 3, 0,        0, 32'h0};
        vecs[12] = '{24, 0, 1, 2, -4096,    1, 32'h8020C063};
        vecs[13] = '{18, 0, 0, 0, 1048574,  1, 32'h7FFFF06F};
        vecs[14] = '{7,  1, 0, 0, 2047,     1, 32'h7FF00093};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset");
        check("reset.in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // Directed vector table; a restart is inserted whenever the memory is full.
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            if (m_mode != 1 || i == 8) pulse_start();
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.we", i), 32'(mem_we), 32'(vecs[i].we));
            if (vecs[i].we) check($sformatf("vec%0d.word", i), mem_wdata, vecs[i].word);
        end
        in_valid = 1'b0;
        check("table.err", 32'(err), 32'd1);
        check("table.err_op", 32'(err_op), 32'd17);

        // Fill to capacity, then hold a request against a full memory.
        pulse_start();
        for (int i = 0; i < CAP; i++) begin
            drive(7, i + 1, 0, 0, i);
            tick("fill");
        end
        check("fill.full", 32'(full), 32'd1);
        check("fill.ready", 32'(in_ready), 32'd0);
        drive(7, 9, 0, 0, 5);
        repeat (3) tick("held");
        pulse_start();
        check("restart.count", 32'(count), 32'd0);
        drive(9, 2, 3, 0, 100);
        tick("restart.wr");
        check("restart.addr", 32'(mem_addr), 32'd0);

        // finish in the same cycle as a request wins, and the encoder goes idle.
        drive(0, 1, 2, 3, 0);
        finish = 1'b1;
        tick("finish");
        finish = 1'b0;
        tick("idle");
        check("idle.ready", 32'(in_ready), 32'd0);

        // Reset asserted right after a handshake drops the pending strobe.
        pulse_start();
        drive(7, 1, 0, 0, 1);
        #1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        model_reset();
        chk_outputs("rst_drop");
        check("rst_drop.ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int sel, imm;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: imm = int'($urandom_range(0, 40));
                1: imm = int'($urandom_range(0, 4200)) - 2100;
                2: imm = int'($urandom_range(0, 8400)) - 4200;
                3: imm = int'($urandom_range(0, 2200000)) - 1100000;
                4: imm = int'($urandom);
                default: imm = (int'($urandom_range(0, 1)) == 1) ? -4096 : 4094;
            endcase
            drive(int'($urandom_range(0, 27)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
            in_valid = ($urandom_range(0, 9) < 8);
            start    = ($urandom_range(0, 99) < 6) || (m_mode != 1 && $urandom_range(0, 3) == 0);
            finish   = ($urandom_range(0, 99) < 3);
            tick("rand");
        end
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
